// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: single-clock stopwatch sequencer.
// A prescaler turns the system clock into a centisecond tick enable. A
// start/stop/lap/reset state machine drives a BCD mm:ss.cc counter and the
// registered display outputs, including the frozen lap snapshot.
// Optional build macro DEBOUNCE_EN inserts a 2-flop synchroniser and a
// DB_CYCLES stability debouncer in front of the button edge detectors.
module stopwatch_ctrl #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       lap_reset,
    output logic       running,
    output logic       lap_active,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       overflow,
    output logic       tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    // Counter layout: {min_hi, min_lo, sec_hi, sec_lo, cs_hi, cs_lo}
    localparam logic [23:0] CNT_MAX = 24'h995999;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Reject configurations the prescaler and debouncer cannot honour.
    if (DIV < 2 || DB_CYCLES < 1) begin : g_bad_cfg
        $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be >= 2 and DB_CYCLES >= 1");
    end

    // BCD increment of the packed counter; each nibble wraps at its own limit
    // and carries into the next. The top digit wrap is never reached because
    // saturation is caught before the increment is applied.
    function automatic logic [23:0] bcd_inc(input logic [23:0] c);
        logic [23:0] r;
        r = c;
        if (c[3:0] != 4'd9) begin
            r[3:0] = c[3:0] + 4'd1;
        end else begin
            r[3:0] = 4'd0;
            if (c[7:4] != 4'd9) begin
                r[7:4] = c[7:4] + 4'd1;
            end else begin
                r[7:4] = 4'd0;
                if (c[11:8] != 4'd9) begin
                    r[11:8] = c[11:8] + 4'd1;
                end else begin
                    r[11:8] = 4'd0;
                    if (c[15:12] != 4'd5) begin
                        r[15:12] = c[15:12] + 4'd1;
                    end else begin
                        r[15:12] = 4'd0;
                        if (c[19:16] != 4'd9) begin
                            r[19:16] = c[19:16] + 4'd1;
                        end else begin
                            r[19:16] = 4'd0;
                            if (c[23:20] != 4'd9) begin
                                r[23:20] = c[23:20] + 4'd1;
                            end else begin
                                r[23:20] = 4'd0;
                            end
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    logic [1:0]    btn_lvl_s;      // {lap_reset, start_stop} as seen by the edge detectors
    logic          ss_prev_q, lr_prev_q;
    logic          ev_ss_s, ev_lr_s;
    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [23:0]   cnt_q, cnt_d, cnt_post_s;
    logic [23:0]   snap_q, snap_d;
    logic [23:0]   disp_q, disp_d;
    logic          ovf_q, ovf_d;
    logic          running_q, running_d;
    logic          lap_q, lap_d;
    logic          tick_q, tick_d;
    logic          counting_s, tick_s, sat_s, idle_entry_s;

`ifdef DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic [1:0]     sync1_q, sync2_q;
    logic [1:0]     db_lvl_q;
    logic [DBW-1:0] db_cnt_q [2];

    // Two-flop synchroniser; idles high so a held button cannot fire on reset exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= {lap_reset, start_stop};
            sync2_q <= sync1_q;
        end
    end

    // Per-button debouncer: adopt the new level after DB_CYCLES stable cycles.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                db_lvl_q[i] <= 1'b1;
                db_cnt_q[i] <= '0;
            end else if (sync2_q[i] == db_lvl_q[i]) begin
                db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_lvl_q[i] <= sync2_q[i];
                db_cnt_q[i] <= '0;
            end else begin
                db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
        end
    end

    assign btn_lvl_s = db_lvl_q;
`else
    assign btn_lvl_s = {lap_reset, start_stop};
`endif

    // Rising-edge events; start_stop wins when both buttons fire together.
    always_comb begin
        ev_ss_s = btn_lvl_s[0] & ~ss_prev_q;
        ev_lr_s = btn_lvl_s[1] & ~lr_prev_q & ~ev_ss_s;
    end

    // Tick and saturation decode; the tick is applied before any button action.
    always_comb begin
        counting_s = (state_q == ST_RUN) || (state_q == ST_LAP);
        tick_s     = counting_s && (presc_q == PRESC_MAX);
        sat_s      = tick_s && (cnt_q == CNT_MAX);
        if (tick_s && !sat_s) begin
            cnt_post_s = bcd_inc(cnt_q);
        end else begin
            cnt_post_s = cnt_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; saturation overrides any button event.
    always_comb begin
        state_d = state_q;
        if (sat_s) begin
            state_d = ST_PAUSE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_ss_s) state_d = ST_RUN;
                    else         state_d = ST_IDLE;
                end
                ST_RUN: begin
                    if (ev_ss_s)      state_d = ST_PAUSE;
                    else if (ev_lr_s) state_d = ST_LAP;
                    else              state_d = ST_RUN;
                end
                ST_LAP: begin
                    if (ev_ss_s)      state_d = ST_PAUSE;
                    else if (ev_lr_s) state_d = ST_RUN;
                    else              state_d = ST_LAP;
                end
                ST_PAUSE: begin
                    if (ev_ss_s && !ovf_q) state_d = ST_RUN;
                    else if (ev_lr_s)      state_d = ST_IDLE;
                    else                   state_d = ST_PAUSE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs and datapath next values (prescaler, counter, snapshot, display).
    always_comb begin
        idle_entry_s = (state_d == ST_IDLE) && (state_q != ST_IDLE);
        if (idle_entry_s) begin
            presc_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (counting_s) begin
                presc_d = tick_s ? '0 : presc_q + 1'b1;
            end else begin
                presc_d = presc_q;
            end
            cnt_d = cnt_post_s;
            ovf_d = ovf_q | sat_s;
        end
        if ((state_q == ST_RUN) && (state_d == ST_LAP)) begin
            snap_d = cnt_post_s;
        end else begin
            snap_d = snap_q;
        end
        disp_d    = (state_d == ST_LAP) ? snap_d : cnt_d;
        running_d = (state_d == ST_RUN) || (state_d == ST_LAP);
        lap_d     = (state_d == ST_LAP);
        tick_d    = tick_s;
    end

    // Datapath and output registers; button history idles high through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_prev_q <= 1'b1;
            lr_prev_q <= 1'b1;
            presc_q   <= '0;
            cnt_q     <= 24'h000000;
            snap_q    <= 24'h000000;
            disp_q    <= 24'h000000;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            lap_q     <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            ss_prev_q <= btn_lvl_s[0];
            lr_prev_q <= btn_lvl_s[1];
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            disp_q    <= disp_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
            lap_q     <= lap_d;
            tick_q    <= tick_d;
        end
    end

    assign running    = running_q;
    assign lap_active = lap_q;
    assign min_bcd    = disp_q[23:16];
    assign sec_bcd    = disp_q[15:8];
    assign cs_bcd     = disp_q[7:0];
    assign overflow   = ovf_q;
    assign tick       = tick_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl: two instances (DIV=10 and DIV=2) share the
// button stimulus and are compared every cycle against an integer-time model.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss  = 1'b0;
    logic lr  = 1'b0;

    always #5 clk = ~clk;

    logic       r10, l10, ov10, t10, r2, l2, ov2, t2;
    logic [7:0] cs10, sec10, min10, cs2, sec2, min2;

    stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DB_CYCLES(4)) u_dut10 (
        .clk(clk), .rst(rst), .start_stop(ss), .lap_reset(lr),
        .running(r10), .lap_active(l10), .cs_bcd(cs10), .sec_bcd(sec10),
        .min_bcd(min10), .overflow(ov10), .tick(t10)
    );

    stopwatch_ctrl #(.CLK_HZ(200), .TICK_HZ(100), .DB_CYCLES(4)) u_dut2 (
        .clk(clk), .rst(rst), .start_stop(ss), .lap_reset(lr),
        .running(r2), .lap_active(l2), .cs_bcd(cs2), .sec_bcd(sec2),
        .min_bcd(min2), .overflow(ov2), .tick(t2)
    );

    logic [27:0] dv [2];
    assign dv[0] = {r10, l10, ov10, t10, min10, sec10, cs10};
    assign dv[1] = {r2, l2, ov2, t2, min2, sec2, cs2};

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: time kept as an integer count of centiseconds.
    localparam int MAXC = 599999;   // 99:59.99
    int m_div [2] = '{10, 2};
    int m_state [2];                // 0 idle, 1 run, 2 lap, 3 pause
    int m_presc [2];
    int m_cnt [2];
    int m_snap [2];
    int m_disp [2];
    bit m_ovf [2];
    bit m_tick [2];
    bit m_ss_prev, m_lr_prev;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [27:0] exp_vec(input int k);
        int d;
        bit r, l;
        d = m_disp[k];
        r = (m_state[k] == 1) || (m_state[k] == 2);
        l = (m_state[k] == 2);
        return {r, l, m_ovf[k], m_tick[k], to_bcd(d / 6000), to_bcd((d / 100) % 60), to_bcd(d % 100)};
    endfunction

    task automatic model_edge();
        bit ev_ss, ev_lr, cnting, tk, sat;
        int ns;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_state[k] = 0; m_presc[k] = 0; m_cnt[k] = 0; m_snap[k] = 0;
                m_disp[k] = 0; m_ovf[k] = 1'b0; m_tick[k] = 1'b0;
            end
            m_ss_prev = 1'b1;
            m_lr_prev = 1'b1;
        end else begin
            ev_ss = ss && !m_ss_prev;
            ev_lr = lr && !m_lr_prev && !ev_ss;
            m_ss_prev = ss;
            m_lr_prev = lr;
            for (int k = 0; k < 2; k++) begin
                cnting = (m_state[k] == 1) || (m_state[k] == 2);
                tk  = cnting && (m_presc[k] == m_div[k] - 1);
                sat = tk && (m_cnt[k] == MAXC);
                if (tk && !sat) m_cnt[k] = m_cnt[k] + 1;
                if (cnting) m_presc[k] = tk ? 0 : m_presc[k] + 1;
                ns = m_state[k];
                if (sat) begin
                    ns = 3;
                    m_ovf[k] = 1'b1;
                end else begin
                    case (m_state[k])
                        0: if (ev_ss) ns = 1;
                        1: if (ev_ss) ns = 3; else if (ev_lr) begin ns = 2; m_snap[k] = m_cnt[k]; end
                        2: if (ev_ss) ns = 3; else if (ev_lr) ns = 1;
                        default: if (ev_ss && !m_ovf[k]) ns = 1;
                                 else if (ev_lr) begin ns = 0; m_cnt[k] = 0; m_presc[k] = 0; m_ovf[k] = 1'b0; end
                    endcase
                end
                m_state[k] = ns;
                m_disp[k]  = (ns == 2) ? m_snap[k] : m_cnt[k];
                m_tick[k]  = tk;
            end
        end
    endtask

    // One clock: model follows the edge, outputs are then sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; ss = 1'b0; lr = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
    endtask

    task automatic press_ss();
        ss = 1'b1; cycle(); ss = 1'b0;
    endtask

    task automatic press_lr();
        lr = 1'b1; cycle(); lr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ss = 1'b0; lr = 1'b0;
        repeat (3) cycle();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dv[k] !== 28'd0) begin
                n_fail++; $display("FAIL reset_outputs dut%0d got %h want 0", k, dv[k]);
            end
            n_tests++;
            if (dv[k] !== exp_vec(k)) begin
                n_fail++; $display("FAIL reset_model dut%0d got %h want %h", k, dv[k], exp_vec(k));
            end
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_basic_run();
        int ticks;
        do_reset();
        press_ss();
        ticks = 0;
        repeat (250) begin
            cycle();
            if (t10) ticks++;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dv[k] !== exp_vec(k)) begin
                    n_fail++; $display("FAIL basic_model dut%0d got %h want %h", k, dv[k], exp_vec(k));
                end
            end
        end
        n_tests++;
        if (ticks != 25) begin n_fail++; $display("FAIL basic_ticks got %0d want 25", ticks); end
        n_tests++;
        if (cs10 !== 8'h25 || r10 !== 1'b1) begin
            n_fail++; $display("FAIL basic_cs got cs=%h run=%b want cs=25 run=1", cs10, r10);
        end
    endtask

    task automatic test_pause_resume();
        int ticks;
        do_reset();
        press_ss();
        repeat (14) cycle();
        press_ss();
        ticks = 0;
        repeat (100) begin
            cycle();
            if (t10 || t2) ticks++;
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dv[k] !== exp_vec(k)) begin
                    n_fail++; $display("FAIL pause_model dut%0d got %h want %h", k, dv[k], exp_vec(k));
                end
            end
        end
        n_tests++;
        if (ticks != 0) begin n_fail++; $display("FAIL pause_no_tick got %0d ticks want 0", ticks); end
        press_ss();
        repeat (5) cycle();
        n_tests++;
        if (cs10 !== 8'h02) begin n_fail++; $display("FAIL resume_fraction got cs=%h want 02", cs10); end
        press_ss();
        press_lr();
        n_tests++;
        if ({r10, min10, sec10, cs10} !== 25'd0 || {r2, min2, sec2, cs2} !== 25'd0) begin
            n_fail++; $display("FAIL pause_clear got %h/%h want 0/0", dv[0], dv[1]);
        end
    endtask

    task automatic test_lap_freeze();
        int ticks;
        do_reset();
        press_ss();
        repeat (1230) cycle();
        press_lr();
        n_tests++;
        if (l10 !== 1'b1 || {min10, sec10, cs10} !== 24'h000123) begin
            n_fail++; $display("FAIL lap_snapshot got lap=%b %h want lap=1 000123", l10, {min10, sec10, cs10});
        end
        ticks = 0;
        repeat (500) begin
            cycle();
            if (t10) ticks++;
            n_tests++;
            if ({min10, sec10, cs10} !== 24'h000123) begin
                n_fail++; $display("FAIL lap_frozen got %h want 000123", {min10, sec10, cs10});
            end
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dv[k] !== exp_vec(k)) begin
                    n_fail++; $display("FAIL lap_model dut%0d got %h want %h", k, dv[k], exp_vec(k));
                end
            end
        end
        n_tests++;
        if (ticks != 50) begin n_fail++; $display("FAIL lap_ticks got %0d want 50", ticks); end
        press_lr();
        n_tests++;
        if (l10 !== 1'b0 || r10 !== 1'b1 || {min10, sec10, cs10} !== 24'h000173) begin
            n_fail++; $display("FAIL lap_release got lap=%b run=%b %h want 0 1 000173", l10, r10, {min10, sec10, cs10});
        end
    endtask

    task automatic test_carry_chain();
        logic [23:0] v;
        bit bad;
        do_reset();
        press_ss();
        repeat (11999) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dv[k] !== exp_vec(k)) begin
                    n_fail++; $display("FAIL carry_model dut%0d got %h want %h", k, dv[k], exp_vec(k));
                end
            end
            v = {min2, sec2, cs2};
            bad = 1'b0;
            for (int n = 0; n < 6; n++) if (v[n*4 +: 4] > 4'd9) bad = 1'b1;
            n_tests++;
            if (bad) begin n_fail++; $display("FAIL carry_bcd_legal got %h want all nibbles <= 9", v); end
        end
        n_tests++;
        if ({min2, sec2, cs2} !== 24'h005999) begin
            n_fail++; $display("FAIL carry_pre got %h want 005999", {min2, sec2, cs2});
        end
        cycle();
        n_tests++;
        if ({min2, sec2, cs2} !== 24'h010000) begin
            n_fail++; $display("FAIL carry_min got %h want 010000", {min2, sec2, cs2});
        end
    endtask

    task automatic test_saturation();
        press_ss();                     // both instances pause
        @(negedge clk);
        force u_dut2.cnt_q = 24'h995998;
        m_cnt[1] = 599998;
        cycle();
        release u_dut2.cnt_q;
        press_ss();
        repeat (8) begin
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dv[k] !== exp_vec(k)) begin
                    n_fail++; $display("FAIL sat_model dut%0d got %h want %h", k, dv[k], exp_vec(k));
                end
            end
        end
        n_tests++;
        if ({min2, sec2, cs2} !== 24'h995999 || ov2 !== 1'b1 || r2 !== 1'b0) begin
            n_fail++; $display("FAIL sat_hold got %h ov=%b run=%b want 995999 1 0", {min2, sec2, cs2}, ov2, r2);
        end
        press_ss();
        cycle();
        n_tests++;
        if (r2 !== 1'b0 || {min2, sec2, cs2} !== 24'h995999) begin
            n_fail++; $display("FAIL sat_start_ignored got run=%b %h want 0 995999", r2, {min2, sec2, cs2});
        end
        press_lr();
        n_tests++;
        if (ov2 !== 1'b0 || r2 !== 1'b0 || {min2, sec2, cs2} !== 24'h000000) begin
            n_fail++; $display("FAIL sat_clear got ov=%b run=%b %h want 0 0 000000", ov2, r2, {min2, sec2, cs2});
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_ss();
        repeat (7) cycle();
        ss = 1'b1; lr = 1'b1;
        cycle();
        ss = 1'b0; lr = 1'b0;
        cycle();
        n_tests++;
        if (r10 !== 1'b0 || l10 !== 1'b0 || r2 !== 1'b0 || l2 !== 1'b0) begin
            n_fail++; $display("FAIL both_buttons got run=%b%b lap=%b%b want 00 00", r10, r2, l10, l2);
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (dv[k] !== exp_vec(k)) begin
                n_fail++; $display("FAIL both_model dut%0d got %h want %h", k, dv[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_held_through_reset();
        rst = 1'b1; ss = 1'b1; lr = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (5) cycle();
        n_tests++;
        if (r10 !== 1'b0 || r2 !== 1'b0 || l10 !== 1'b0) begin
            n_fail++; $display("FAIL held_reset got run=%b%b lap=%b want 00 0", r10, r2, l10);
        end
        ss = 1'b0; lr = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        press_ss();
        repeat (37) cycle();
        rst = 1'b1;
        cycle();
        n_tests++;
        if (dv[0] !== 28'd0 || dv[1] !== 28'd0) begin
            n_fail++; $display("FAIL reset_mid_run got %h/%h want 0/0", dv[0], dv[1]);
        end
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        repeat (4000) begin
            if ($urandom_range(0, 15) == 0) ss = ~ss;
            if ($urandom_range(0, 15) == 0) lr = ~lr;
            rst = ($urandom_range(0, 999) == 0);
            cycle();
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (dv[k] !== exp_vec(k)) begin
                    n_fail++; $display("FAIL random_model dut%0d got %h want %h", k, dv[k], exp_vec(k));
                end
            end
        end
        rst = 1'b0; ss = 1'b0; lr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_pause_resume();
        test_lap_freeze();
        test_carry_chain();
        test_saturation();
        test_simultaneous();
        test_held_through_reset();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
